// File: rtl/instruction_fetch.sv
// instruction_fetch: program counter and fetch sequencer for the 9-bit core.
// Steps the PC through instruction ROM, applies taken branches resolved in
// the same cycle, runs the start/done handshake and counts retired
// instructions for performance measurement.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | after reset; pc=0, decoder held in init, waiting for start
//   LOAD   | one-cycle preload; pc and retired count forced to 0
//   RUN    | fetching; one instruction retires per non-stalled cycle
//   DONE   | program ended (halt or sequential end); pc/count frozen
module instruction_fetch #(
    parameter int PC_W      = 10,
    parameter int LAST_ADDR = 1023,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    input  logic             halt,
    input  logic             branch,
    input  logic             branch_taken,
    input  logic [PC_W-1:0]  branch_target,
    input  logic [8:0]       imem_data,
    output logic [PC_W-1:0]  pc,
    output logic [8:0]       instruction,
    output logic             init,
    output logic             done,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [PC_W-1:0]  LAST_PC = PC_W'(LAST_ADDR);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state;
    state_t           state_next;
    logic [PC_W-1:0]  pc_next;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] count_inc;
    logic             retire;

    // saturating increment of the retired-instruction counter
    always_comb begin
        count_inc = instr_count;
        if (instr_count != CNT_MAX) begin
            count_inc = instr_count + CNT_W'(1);
        end
    end

    // next-state, next-pc and next-count decode
    always_comb begin
        state_next = state;
        pc_next    = pc;
        count_next = instr_count;
        retire     = 1'b0;

        case (state)
            S_IDLE: begin
                pc_next = '0;
                if (start) begin
                    state_next = S_LOAD;
                    count_next = '0;
                end
            end

            // pc/count are already zero on entry so the LOAD cycle itself
            // presents a clean pc=0 and count=0
            S_LOAD: begin
                pc_next    = '0;
                count_next = '0;
                state_next = S_RUN;
            end

            S_RUN: begin
                if (!stall) begin
                    retire     = 1'b1;
                    count_next = count_inc;
                    if (halt) begin
                        state_next = S_DONE;
                    end else if (branch && branch_taken) begin
                        // a taken branch wins even from the last address
                        pc_next = branch_target;
                    end else if (pc >= LAST_PC) begin
                        state_next = S_DONE;
                    end else begin
                        pc_next = pc + PC_W'(1);
                    end
                end
            end

            S_DONE: begin
                if (start) begin
                    state_next = S_LOAD;
                    pc_next    = '0;
                    count_next = '0;
                end
            end

            default: begin
                state_next = S_IDLE;
                pc_next    = '0;
                count_next = '0;
            end
        endcase
    end

    // state, pc and counter registers; reset returns to IDLE at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= '0;
            instr_count <= '0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            instr_count <= count_next;
        end
    end

    // decoder-facing outputs: init/done from state only, instruction gated by RUN
    always_comb begin
        init        = (state != S_RUN);
        done        = (state == S_DONE);
        instruction = (state == S_RUN) ? imem_data : 9'b0;
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch. Two instances share stimulus:
// dut_a is a tiny core (LAST_ADDR=4, 3-bit counter) and dut_b a wider one.
// A behavioural model of each is checked every cycle, plus directed checks.
module tb_instruction_fetch;

    localparam int A_PC_W  = 5;
    localparam int A_LAST  = 4;
    localparam int A_CNT_W = 3;
    localparam int B_PC_W  = 6;
    localparam int B_LAST  = 40;
    localparam int B_CNT_W = 16;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_RUN  = 2;
    localparam int M_DONE = 3;

    typedef struct packed {
        int st;
        int pc;
        int cnt;
    } mst_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic stall = 1'b0;
    logic halt = 1'b0;
    logic branch = 1'b0;
    logic branch_taken = 1'b0;
    logic [5:0] target = '0;

    logic [8:0] rom_a [32];
    logic [8:0] rom_b [64];

    logic [A_PC_W-1:0]  pc_a;
    logic [8:0]         imem_a, instr_a;
    logic               init_a, done_a;
    logic [A_CNT_W-1:0] cnt_a;

    logic [B_PC_W-1:0]  pc_b;
    logic [8:0]         imem_b, instr_b;
    logic               init_b, done_b;
    logic [B_CNT_W-1:0] cnt_b;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    mst_t ma = '0;
    mst_t mb = '0;

    assign imem_a = rom_a[pc_a];
    assign imem_b = rom_b[pc_b];

    always #5 clk = ~clk;

    instruction_fetch #(.PC_W(A_PC_W), .LAST_ADDR(A_LAST), .CNT_W(A_CNT_W)) dut_a (
        .clk(clk), .reset(reset), .start(start), .stall(stall), .halt(halt),
        .branch(branch), .branch_taken(branch_taken), .branch_target(target[4:0]),
        .imem_data(imem_a), .pc(pc_a), .instruction(instr_a), .init(init_a),
        .done(done_a), .instr_count(cnt_a)
    );

    instruction_fetch #(.PC_W(B_PC_W), .LAST_ADDR(B_LAST), .CNT_W(B_CNT_W)) dut_b (
        .clk(clk), .reset(reset), .start(start), .stall(stall), .halt(halt),
        .branch(branch), .branch_taken(branch_taken), .branch_target(target),
        .imem_data(imem_b), .pc(pc_b), .instruction(instr_b), .init(init_b),
        .done(done_b), .instr_count(cnt_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // one machine step from the rules of operation
    function automatic mst_t mstep(mst_t s, logic st_in, logic stl, logic hlt, logic br,
                                   logic tk, int tgt, int last, int pmod, int cmax);
        mst_t n = s;
        case (s.st)
            M_IDLE: if (st_in) begin n.st = M_LOAD; n.pc = 0; n.cnt = 0; end
            M_LOAD: begin n.st = M_RUN; n.pc = 0; n.cnt = 0; end
            M_RUN: if (!stl) begin
                n.cnt = (s.cnt < cmax) ? s.cnt + 1 : cmax;
                if (hlt)             n.st = M_DONE;
                else if (br && tk)   n.pc = tgt % pmod;
                else if (s.pc >= last) n.st = M_DONE;
                else                 n.pc = (s.pc + 1) % pmod;
            end
            default: if (st_in) begin n.st = M_LOAD; n.pc = 0; n.cnt = 0; end
        endcase
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ma <= '0;
            mb <= '0;
        end else begin
            ma <= mstep(ma, start, stall, halt, branch, branch_taken, int'(target),
                        A_LAST, 32, 7);
            mb <= mstep(mb, start, stall, halt, branch, branch_taken, int'(target),
                        B_LAST, 64, 65535);
        end
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            check("a_pc",    pc_a,    ma.pc);
            check("a_cnt",   cnt_a,   ma.cnt);
            check("a_init",  init_a,  ma.st != M_RUN);
            check("a_done",  done_a,  ma.st == M_DONE);
            check("a_instr", instr_a, (ma.st == M_RUN) ? rom_a[ma.pc] : 9'd0);
            check("b_pc",    pc_b,    mb.pc);
            check("b_cnt",   cnt_b,   mb.cnt);
            check("b_init",  init_b,  mb.st != M_RUN);
            check("b_done",  done_b,  mb.st == M_DONE);
            check("b_instr", instr_b, (mb.st == M_RUN) ? rom_b[mb.pc] : 9'd0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom_a[i] = 9'($urandom_range(1, 511));
        for (int i = 0; i < 64; i++) rom_b[i] = 9'($urandom_range(1, 511));
        #1 reset = 1'b1;
        #1 cmp_en = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();

        // reset state
        check("rst_pc",    pc_a,    0);
        check("rst_init",  init_a,  1);
        check("rst_done",  done_a,  0);
        check("rst_cnt",   cnt_a,   0);
        check("rst_instr", instr_a, 0);

        // five NOPs, LAST_ADDR=4
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("load_init", init_a, 1);
        check("load_pc",   pc_a,   0);
        cyc();
        check("run_init",  init_a, 0);
        check("run_pc0",   pc_a,   0);
        check("run_instr0", instr_a, rom_a[0]);
        for (int i = 1; i < 5; i++) begin
            cyc();
            check("nop_pc", pc_a, i);
        end
        cyc();
        check("nop_done", done_a, 1);
        check("nop_init", init_a, 1);
        check("nop_pc_end", pc_a, 4);
        check("nop_cnt", cnt_a, 5);

        // taken branch at pc=2 to 7, then not-taken at 7
        do_reset();
        start = 1'b1; cyc(); start = 1'b0; cyc();
        cyc(); cyc();
        check("br_pre_pc", pc_b, 2);
        branch = 1'b1; branch_taken = 1'b1; target = 6'd7;
        cyc();
        check("br_taken_pc", pc_b, 7);
        branch_taken = 1'b0;
        cyc();
        check("br_nt_pc", pc_b, 8);
        branch = 1'b0;
        check("br_cnt", cnt_b, 4);

        // halt at pc=3 behind a 2-cycle stall, then restart from DONE
        do_reset();
        start = 1'b1; cyc(); start = 1'b0; cyc();
        cyc(); cyc(); cyc();
        stall = 1'b1; halt = 1'b1;
        cyc();
        check("stl_pc1", pc_b, 3);
        check("stl_done1", done_b, 0);
        cyc();
        check("stl_pc2", pc_b, 3);
        check("stl_cnt", cnt_b, 3);
        stall = 1'b0;
        cyc();
        halt = 1'b0;
        check("halt_done", done_b, 1);
        check("halt_pc", pc_b, 3);
        check("halt_cnt", cnt_b, 4);
        cyc();
        check("done_hold", done_b, 1);
        check("done_pc", pc_b, 3);
        start = 1'b1; cyc(); start = 1'b0;
        check("rs_pc", pc_b, 0);
        check("rs_cnt", cnt_b, 0);
        check("rs_done", done_b, 0);
        check("rs_init", init_b, 1);
        cyc();
        check("rs_run", init_b, 0);
        cyc(); cyc();
        halt = 1'b1; cyc(); halt = 1'b0;
        check("rs2_done", done_b, 1);
        check("rs2_cnt", cnt_b, 3);
        check("rs2_pc", pc_b, 2);

        // start held through RUN, then async reset at pc=6
        do_reset();
        start = 1'b1; cyc(); cyc();
        repeat (6) cyc();
        check("hold_pc", pc_b, 6);
        check("hold_cnt", cnt_b, 6);
        check("hold_init", init_b, 0);
        #1 reset = 1'b1;
        #1;
        check("ar_pc", pc_b, 0);
        check("ar_cnt", cnt_b, 0);
        check("ar_init", init_b, 1);
        check("ar_done", done_b, 0);
        check("ar_instr", instr_b, 0);
        start = 1'b0;
        cyc();
        reset = 1'b0;
        cyc();

        // 10-instruction program on the 3-bit counter, branching from LAST_ADDR
        do_reset();
        start = 1'b1; cyc(); start = 1'b0; cyc();
        for (int j = 0; j < 10; j++) begin
            branch = (j == 4); branch_taken = (j == 4); target = 6'd0;
            cyc();
            if (j == 4) begin
                check("last_br_pc", pc_a, 0);
                check("last_br_done", done_a, 0);
            end
        end
        branch = 1'b0; branch_taken = 1'b0;
        check("sat_done", done_a, 1);
        check("sat_cnt", cnt_a, 7);
        check("sat_pc", pc_a, 4);

        // randomized traffic against the model
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            reset        = ($urandom_range(0, 199) == 0);
            start        = ($urandom_range(0, 9) == 0);
            stall        = ($urandom_range(0, 4) == 0);
            halt         = ($urandom_range(0, 24) == 0);
            branch       = ($urandom_range(0, 3) == 0);
            branch_taken = 1'($urandom_range(0, 1));
            target       = 6'($urandom_range(0, 63));
            cyc();
        end
        reset = 1'b0; start = 1'b0; stall = 1'b0; halt = 1'b0;
        branch = 1'b0; branch_taken = 1'b0;
        cyc();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
